mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter.sv | 70 +++++++
 tb/tb_mem_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester A/B request, grant and read-return bus; master = requesters, slave = arbiter
interface mem_arbiter_if;
    logic        a_req;
    logic        b_req;
    logic [1:0]  a_cmd;
    logic [1:0]  b_cmd;
    logic [8:0]  a_addr;
    logic [8:0]  b_addr;
    logic [15:0] a_wdata;
    logic [15:0] b_wdata;
    logic        a_gnt;
    logic        b_gnt;
    logic        a_rvalid;
    logic        b_rvalid;
    logic [15:0] rdata;
    modport master (
        output a_req, b_req, a_cmd, b_cmd, a_addr, b_addr, a_wdata, b_wdata,
        input  a_gnt, b_gnt, a_rvalid, b_rvalid, rdata
    );
    modport slave (
        input  a_req, b_req, a_cmd, b_cmd, a_addr, b_addr, a_wdata, b_wdata,
        output a_gnt, b_gnt, a_rvalid, b_rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-requester arbiter for a RAM, an LED register and a switch port; ports: clk, reset (async active-low), bus (requester A/B handshake), ram_addr/ram_we/ram_din/ram_dout (registered-output RAM), sw (switches), led (LED register)
module mem_arbiter #(
    parameter logic [8:0] LED_ADDR = 9'h100,
    parameter logic [8:0] SW_ADDR  = 9'h140
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus,
    output logic [7:0]  ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_din,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  sw,
    output logic [7:0]  led
);
    typedef enum logic {IDLE, RD_WAIT} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_SW} src_t;
    localparam logic [1:0] MREAD = 2'b01, MWRITE = 2'b10;
    state_t      state;
    src_t        src;
    logic        prio_b;
    logic        who_b;
    logic [15:0] rd_reg;
    logic        a_pend, b_pend, pick_b, grant, rvalid;
    logic [1:0]  g_cmd;
    logic [8:0]  g_addr;
    logic [15:0] g_wdata;
    always_comb begin
        a_pend       = bus.a_req && (bus.a_cmd == MREAD || bus.a_cmd == MWRITE);
        b_pend       = bus.b_req && (bus.b_cmd == MREAD || bus.b_cmd == MWRITE);
        pick_b       = b_pend && (!a_pend || prio_b);
        // reset gating keeps every strobe low while reset is held, regardless of inputs
        grant        = reset && state == IDLE && (a_pend || b_pend);
        rvalid       = reset && state == RD_WAIT;
        g_cmd        = pick_b ? bus.b_cmd : bus.a_cmd;
        g_addr       = pick_b ? bus.b_addr : bus.a_addr;
        g_wdata      = pick_b ? bus.b_wdata : bus.a_wdata;
        bus.a_gnt    = grant && !pick_b;
        bus.b_gnt    = grant && pick_b;
        bus.a_rvalid = rvalid && !who_b;
        bus.b_rvalid = rvalid && who_b;
        bus.rdata    = !rvalid ? 16'h0000 : src == SRC_RAM ? ram_dout : src == SRC_SW ? rd_reg : 16'h0000;
        ram_addr     = grant ? g_addr[7:0] : 8'h00;
        ram_din      = grant ? g_wdata : 16'h0000;
        ram_we       = grant && g_cmd == MWRITE && !g_addr[8];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            prio_b <= 1'b0;
            led    <= 8'h00;
            rd_reg <= 16'h0000;
            src    <= SRC_NONE;
            who_b  <= 1'b0;
        end else if (state == RD_WAIT) begin
            state <= IDLE;
        end else if (grant) begin
            prio_b <= !pick_b;
            if (g_cmd == MWRITE && g_addr == LED_ADDR)
                led <= g_wdata[7:0];
            if (g_cmd == MREAD) begin
                state <= RD_WAIT;
                who_b <= pick_b;
                src   <= !g_addr[8] ? SRC_RAM : g_addr == SW_ADDR ? SRC_SW : SRC_NONE;
                if (g_addr == SW_ADDR)
                    rd_reg <= {8'h00, sw};
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table plus reset/round-robin sequences for mem_arbiter
module tb_mem_arbiter;
    localparam logic [1:0] N = 2'b00, R = 2'b01, W = 2'b10;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_din;
    logic [15:0] ram_dout = 16'h0000;
    logic [7:0]  sw = 8'h00;
    logic [7:0]  led;
    logic [15:0] mem [256];
    int checks = 0;
    int failures = 0;
    mem_arbiter_if bus();
    mem_arbiter dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .sw(sw), .led(led)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end
    typedef struct {
        logic ar; logic [1:0] ac; logic [8:0] aa; logic [15:0] aw;
        logic br; logic [1:0] bc; logic [8:0] ba; logic [15:0] bw;
        logic [7:0] sw;
        logic ag; logic bg; logic av; logic bv;
        logic [15:0] rd; logic we; logic [7:0] ra; logic [15:0] rdin; logic [7:0] led;
    } vec_t;
    vec_t v [17];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic ar, input logic [1:0] ac, input logic [8:0] aa, input logic [15:0] aw,
                         input logic br, input logic [1:0] bc, input logic [8:0] ba, input logic [15:0] bw);
        bus.a_req = ar; bus.a_cmd = ac; bus.a_addr = aa; bus.a_wdata = aw;
        bus.b_req = br; bus.b_cmd = bc; bus.b_addr = ba; bus.b_wdata = bw;
    endtask
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        v[0]  = '{0,N,9'h000,16'h0000, 0,N,9'h000,16'h0000, 8'h00, 0,0,0,0, 16'h0000,0,8'h00,16'h0000,8'h00};
        v[1]  = '{1,W,9'h005,16'hBEEF, 0,N,9'h000,16'h0000, 8'h00, 1,0,0,0, 16'h0000,1,8'h05,16'hBEEF,8'h00};
        v[2]  = '{1,R,9'h005,16'h0000, 0,N,9'h000,16'h0000, 8'h00, 1,0,0,0, 16'h0000,0,8'h05,16'h0000,8'h00};
        v[3]  = '{0,N,9'h000,16'h0000, 0,N,9'h000,16'h0000, 8'h00, 0,0,1,0, 16'hBEEF,0,8'h00,16'h0000,8'h00};
        v[4]  = '{0,N,9'h000,16'h0000, 1,W,9'h100,16'h12A5, 8'h00, 0,1,0,0, 16'h0000,0,8'h00,16'h12A5,8'h00};
        v[5]  = '{0,N,9'h000,16'h0000, 0,N,9'h000,16'h0000, 8'h00, 0,0,0,0, 16'h0000,0,8'h00,16'h0000,8'hA5};
        v[6]  = '{1,R,9'h140,16'h0000, 0,N,9'h000,16'h0000, 8'h3C, 1,0,0,0, 16'h0000,0,8'h40,16'h0000,8'hA5};
        v[7]  = '{0,N,9'h000,16'h0000, 0,N,9'h000,16'h0000, 8'hFF, 0,0,1,0, 16'h003C,0,8'h00,16'h0000,8'hA5};
        v[8]  = '{1,R,9'h1F0,16'h0000, 1,W,9'h010,16'h5555, 8'h00, 0,1,0,0, 16'h0000,1,8'h10,16'h5555,8'hA5};
        v[9]  = '{1,R,9'h1F0,16'h0000, 1,R,9'h010,16'h0000, 8'h00, 1,0,0,0, 16'h0000,0,8'hF0,16'h0000,8'hA5};
        v[10] = '{0,N,9'h000,16'h0000, 1,R,9'h010,16'h0000, 8'h00, 0,0,1,0, 16'h0000,0,8'h00,16'h0000,8'hA5};
        v[11] = '{0,N,9'h000,16'h0000, 1,R,9'h010,16'h0000, 8'h00, 0,1,0,0, 16'h0000,0,8'h10,16'h0000,8'hA5};
        v[12] = '{0,N,9'h000,16'h0000, 0,N,9'h000,16'h0000, 8'h00, 0,0,0,1, 16'h5555,0,8'h00,16'h0000,8'hA5};
        v[13] = '{1,2'b11,9'h010,16'h0000, 1,N,9'h010,16'h0000, 8'h00, 0,0,0,0, 16'h0000,0,8'h00,16'h0000,8'hA5};
        v[14] = '{1,W,9'h1AB,16'h7777, 0,N,9'h000,16'h0000, 8'h00, 1,0,0,0, 16'h0000,0,8'hAB,16'h7777,8'hA5};
        v[15] = '{1,W,9'h0FF,16'h00FF, 0,N,9'h000,16'h0000, 8'h00, 1,0,0,0, 16'h0000,1,8'hFF,16'h00FF,8'hA5};
        v[16] = '{0,N,9'h000,16'h0000, 0,N,9'h000,16'h0000, 8'h00, 0,0,0,0, 16'h0000,0,8'h00,16'h0000,8'hA5};
        drive(1, W, 9'h005, 16'h1111, 1, R, 9'h006, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_gnt", {31'd0, bus.a_gnt}, 0);
        chk("rst_b_gnt", {31'd0, bus.b_gnt}, 0);
        chk("rst_we", {31'd0, ram_we}, 0);
        chk("rst_ram_addr", {24'd0, ram_addr}, 0);
        chk("rst_ram_din", {16'd0, ram_din}, 0);
        chk("rst_rdata", {16'd0, bus.rdata}, 0);
        chk("rst_led", {24'd0, led}, 0);
        drive(0, N, 9'h000, 16'h0000, 0, N, 9'h000, 16'h0000);
        reset = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #1;
            drive(v[i].ar, v[i].ac, v[i].aa, v[i].aw, v[i].br, v[i].bc, v[i].ba, v[i].bw);
            sw = v[i].sw;
            @(negedge clk);
            chk($sformatf("v%0d_a_gnt", i), {31'd0, bus.a_gnt}, {31'd0, v[i].ag});
            chk($sformatf("v%0d_b_gnt", i), {31'd0, bus.b_gnt}, {31'd0, v[i].bg});
            chk($sformatf("v%0d_a_rvalid", i), {31'd0, bus.a_rvalid}, {31'd0, v[i].av});
            chk($sformatf("v%0d_b_rvalid", i), {31'd0, bus.b_rvalid}, {31'd0, v[i].bv});
            chk($sformatf("v%0d_rdata", i), {16'd0, bus.rdata}, {16'd0, v[i].rd});
            chk($sformatf("v%0d_we", i), {31'd0, ram_we}, {31'd0, v[i].we});
            chk($sformatf("v%0d_ram_addr", i), {24'd0, ram_addr}, {24'd0, v[i].ra});
            chk($sformatf("v%0d_ram_din", i), {16'd0, ram_din}, {16'd0, v[i].rdin});
            chk($sformatf("v%0d_led", i), {24'd0, led}, {24'd0, v[i].led});
        end
        // read granted, then reset pulsed low while the read is outstanding
        @(posedge clk);
        #1;
        drive(1, R, 9'h005, 16'h0000, 0, N, 9'h000, 16'h0000);
        @(negedge clk);
        chk("rdw_a_gnt", {31'd0, bus.a_gnt}, 1);
        @(posedge clk);
        #1;
        drive(1, W, 9'h1AA, 16'h0001, 1, W, 9'h1AA, 16'h0002);
        reset = 1'b0;
        #1;
        chk("rdw_rst_a_rvalid", {31'd0, bus.a_rvalid}, 0);
        chk("rdw_rst_rdata", {16'd0, bus.rdata}, 0);
        chk("rdw_rst_led", {24'd0, led}, 0);
        chk("rdw_rst_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 0);
        chk("rdw_rst_ram_addr", {24'd0, ram_addr}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        // both requesters hold write requests continuously: grants must alternate starting at A
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_a_gnt", i), {31'd0, bus.a_gnt}, {31'd0, i % 2 == 0});
            chk($sformatf("rr%0d_b_gnt", i), {31'd0, bus.b_gnt}, {31'd0, i % 2 == 1});
            chk($sformatf("rr%0d_rvalid", i), {30'd0, bus.a_rvalid, bus.b_rvalid}, 0);
            chk($sformatf("rr%0d_we", i), {31'd0, ram_we}, 0);
            chk($sformatf("rr%0d_led", i), {24'd0, led}, 0);
        end
        drive(0, N, 9'h000, 16'h0000, 0, N, 9'h000, 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
